// File: rtl/regfile_wb_pkg.sv
// Shared widths and the load-buffer entry type for the regfile write-back controller.
package regfile_wb_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_if.sv
// Bundle between execute/memory, issue and the regfile write port.
// The master side is the upstream producer; the slave side is the write-back controller.
interface regfile_wb_if #(
  parameter int ADDR_W = regfile_wb_pkg::ADDR_W,
  parameter int DATA_W = regfile_wb_pkg::DATA_W,
  parameter int NREG   = regfile_wb_pkg::NREG,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              claim_valid;
  logic [ADDR_W-1:0] claim_addr;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              we3;
  logic [ADDR_W-1:0] addr3;
  logic [DATA_W-1:0] writeData3;
  logic [NREG-1:0]   busy;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output claim_valid, claim_addr,
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready, we3, addr3, writeData3, busy, fifo_count
  );

  modport slave (
    input  claim_valid, claim_addr,
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready, we3, addr3, writeData3, busy, fifo_count
  );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// Synchronous FIFO of write-back entries; pointers wrap naturally since DEPTH is a power of two.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        din,
  output wb_entry_t        dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage is not reset: a flushed entry is unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Serialises ALU and load results onto the single regfile write port and keeps the
// per-register busy scoreboard used by issue for RAW stalls.
module regfile_writeback #(
  parameter int ADDR_W = regfile_wb_pkg::ADDR_W,
  parameter int DATA_W = regfile_wb_pkg::DATA_W,
  parameter int NREG   = regfile_wb_pkg::NREG,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  regfile_wb_if.slave bus
);
  import regfile_wb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t         push_entry, head;
  logic              fifo_full, fifo_empty, push, pop;
  logic [CNT_W-1:0]  count, count_next;

  logic              ready_q, ready_d;
  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] addr3_q, addr3_d;
  logic [DATA_W-1:0] data3_q, data3_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // mem_ready comes from a register so no upstream input can reach it combinationally.
  assign push       = bus.mem_valid && ready_q && !fifo_full;
  assign pop        = !bus.alu_valid && !fifo_empty;
  assign push_entry = '{addr: bus.mem_addr, data: bus.mem_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    sel_valid  = bus.alu_valid || !fifo_empty;
    sel_addr   = bus.alu_valid ? bus.alu_addr : head.addr;
    sel_data   = bus.alu_valid ? bus.alu_data : head.data;

    // Out-of-range destinations still consume their buffer slot but never reach the port.
    we3_d      = sel_valid && (int'(sel_addr) < NREG);
    addr3_d    = we3_d ? sel_addr : addr3_q;
    data3_d    = we3_d ? sel_data : data3_q;

    count_next = count + CNT_W'(push) - CNT_W'(pop);
    ready_d    = (count_next < CNT_W'(DEPTH));
  end

  // Clear on retirement first so a same-edge claim of that register wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (we3_q && int'(addr3_q) == i) busy_d[i] = 1'b0;
      if (bus.claim_valid && int'(bus.claim_addr) == i) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      we3_q   <= 1'b0;
      addr3_q <= '0;
      data3_q <= '0;
      busy_q  <= '0;
    end else begin
      ready_q <= ready_d;
      we3_q   <= we3_d;
      addr3_q <= addr3_d;
      data3_q <= data3_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.mem_ready  = ready_q;
  assign bus.we3        = we3_q;
  assign bus.addr3      = addr3_q;
  assign bus.writeData3 = data3_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: ALU/load arbitration, backpressure, scoreboard, reset.
module tb_regfile_writeback;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int DEPTH  = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   k;
  logic acc;

  regfile_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG), .DEPTH(DEPTH)) bus ();

  regfile_writeback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.claim_valid = 1'b0; bus.claim_addr = '0;
    bus.alu_valid   = 1'b0; bus.alu_addr   = '0; bus.alu_data = '0;
    bus.mem_valid   = 1'b0; bus.mem_addr   = '0; bus.mem_data = '0;

    // reset and idle
    tick();
    tick();
    chk("ready_in_reset", 64'(bus.mem_ready), 64'd0);
    reset = 1'b0;
    tick();
    chk("rst_we3",   64'(bus.we3), 64'd0);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_ready", 64'(bus.mem_ready), 64'd1);
    chk("rst_addr3", 64'(bus.addr3), 64'd0);
    chk("rst_data3", 64'(bus.writeData3), 64'd0);

    // single ALU write: one cycle latency, one cycle pulse
    bus.alu_valid = 1'b1; bus.alu_addr = 6'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 1'b0;
    chk("alu_we3",   64'(bus.we3), 64'd1);
    chk("alu_addr3", 64'(bus.addr3), 64'd5);
    chk("alu_data3", 64'(bus.writeData3), 64'hDEADBEEF);
    tick();
    chk("alu_we3_off", 64'(bus.we3), 64'd0);

    // ALU and load in the same cycle: ALU first, load next
    bus.alu_valid = 1'b1; bus.alu_addr = 6'd3; bus.alu_data = 32'h11;
    bus.mem_valid = 1'b1; bus.mem_addr = 6'd7; bus.mem_data = 32'h22;
    tick();
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    chk("mix1_we3",   64'(bus.we3), 64'd1);
    chk("mix1_addr3", 64'(bus.addr3), 64'd3);
    chk("mix1_data3", 64'(bus.writeData3), 64'h11);
    chk("mix1_count", 64'(bus.fifo_count), 64'd1);
    tick();
    chk("mix2_we3",   64'(bus.we3), 64'd1);
    chk("mix2_addr3", 64'(bus.addr3), 64'd7);
    chk("mix2_data3", 64'(bus.writeData3), 64'h22);
    chk("mix2_count", 64'(bus.fifo_count), 64'd0);
    tick();
    chk("mix3_we3", 64'(bus.we3), 64'd0);

    // sustained ALU traffic: four loads accepted, fifth held by backpressure
    k = 0;
    bus.alu_valid = 1'b1; bus.alu_addr = 6'd1;
    for (int c = 0; c < 7; c++) begin
      bus.alu_data  = 32'(c);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = 6'(10 + k);
      bus.mem_data  = 32'h100 + 32'(k);
      acc = bus.mem_ready;
      tick();
      if (acc) k++;
    end
    chk("bp_accepted", 64'(k), 64'd4);
    chk("bp_count",    64'(bus.fifo_count), 64'd4);
    chk("bp_ready",    64'(bus.mem_ready), 64'd0);
    chk("bp_alu_addr", 64'(bus.addr3), 64'd1);
    chk("bp_alu_data", 64'(bus.writeData3), 64'd6);

    // ALU stops: loads retire in order, fifth enters behind them
    bus.alu_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      acc = bus.mem_valid && bus.mem_ready;
      tick();
      if (acc) begin
        k++;
        bus.mem_valid = 1'b0;
      end
      chk($sformatf("drain%0d_we3", j),   64'(bus.we3), 64'd1);
      chk($sformatf("drain%0d_addr3", j), 64'(bus.addr3), 64'(10 + j));
      chk($sformatf("drain%0d_data3", j), 64'(bus.writeData3), 64'h100 + 64'(j));
      if (j == 0) chk("full_no_pushthrough", 64'(bus.fifo_count), 64'd3);
      if (j == 1) chk("refill_count", 64'(bus.fifo_count), 64'd3);
    end
    chk("drain_accepted", 64'(k), 64'd5);
    chk("drain_count",    64'(bus.fifo_count), 64'd0);
    tick();
    chk("drain_idle_we3", 64'(bus.we3), 64'd0);

    // scoreboard
    bus.claim_valid = 1'b1; bus.claim_addr = 6'd9;
    tick();
    bus.claim_valid = 1'b0;
    chk("claim9_busy", 64'(bus.busy), 64'h200);
    bus.alu_valid = 1'b1; bus.alu_addr = 6'd9; bus.alu_data = 32'h99;
    tick();
    bus.alu_valid = 1'b0;
    chk("ret9_pulse_busy", 64'(bus.busy), 64'h200);
    tick();
    chk("ret9_cleared", 64'(bus.busy), 64'h0);
    bus.alu_valid = 1'b1; bus.alu_addr = 6'd9; bus.alu_data = 32'h98;
    tick();
    bus.alu_valid = 1'b0;
    bus.claim_valid = 1'b1; bus.claim_addr = 6'd9;
    tick();
    bus.claim_valid = 1'b0;
    chk("set_wins_busy", 64'(bus.busy), 64'h200);
    bus.claim_valid = 1'b1; bus.claim_addr = 6'd40;
    tick();
    bus.claim_valid = 1'b0;
    chk("claim40_ignored", 64'(bus.busy), 64'h200);

    // reset with three loads buffered behind ALU traffic
    bus.alu_valid = 1'b1; bus.alu_addr = 6'd2; bus.alu_data = 32'h5;
    for (int c = 0; c < 3; c++) begin
      bus.mem_valid = 1'b1;
      bus.mem_addr  = 6'(20 + c);
      bus.mem_data  = 32'h200 + 32'(c);
      tick();
    end
    bus.mem_valid = 1'b0;
    chk("pre_reset_count", 64'(bus.fifo_count), 64'd3);
    bus.alu_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_count", 64'(bus.fifo_count), 64'd0);
    chk("mid_rst_busy",  64'(bus.busy), 64'd0);
    chk("mid_rst_we3",   64'(bus.we3), 64'd0);
    tick();
    chk("post_rst_we3",   64'(bus.we3), 64'd0);
    chk("post_rst_ready", 64'(bus.mem_ready), 64'd1);
    tick();
    chk("post_rst_we3b",  64'(bus.we3), 64'd0);

    // out-of-range destinations are dropped, register 0 is ordinary
    bus.alu_valid = 1'b1; bus.alu_addr = 6'd40; bus.alu_data = 32'h40;
    tick();
    bus.alu_valid = 1'b0;
    chk("alu40_we3", 64'(bus.we3), 64'd0);
    bus.mem_valid = 1'b1; bus.mem_addr = 6'd40; bus.mem_data = 32'h41;
    tick();
    bus.mem_valid = 1'b0;
    chk("mem40_count", 64'(bus.fifo_count), 64'd1);
    tick();
    chk("mem40_we3",   64'(bus.we3), 64'd0);
    chk("mem40_drain", 64'(bus.fifo_count), 64'd0);
    bus.alu_valid = 1'b1; bus.alu_addr = 6'd0; bus.alu_data = 32'hA5A5;
    tick();
    bus.alu_valid = 1'b0;
    chk("r0_we3",   64'(bus.we3), 64'd1);
    chk("r0_addr3", 64'(bus.addr3), 64'd0);
    chk("r0_data3", 64'(bus.writeData3), 64'hA5A5);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
